// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_pkg;
  localparam int DMEM_ADDR_W  = 8;
  localparam int DMEM_WDATA_W = 8;
  localparam int DMEM_RDATA_W = 16;
  localparam int DMEM_DEPTH   = 33;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int WDATA_W = DMEM_WDATA_W,
  parameter int RDATA_W = DMEM_RDATA_W
);
  logic [1:0]         req;
  logic [1:0]         we;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [WDATA_W-1:0] wdata0;
  logic [WDATA_W-1:0] wdata1;
  logic [1:0]         ack;
  logic               err;
  logic [RDATA_W-1:0] rdata;
  logic               busy;
  logic               mem_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WDATA_W-1:0] mem_wdata;
  logic [RDATA_W-1:0] mem_rdata;

  // master: requesters plus the memory itself; slave: the arbiter
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack, err, rdata, busy, mem_en, mem_addr, mem_wdata
  );
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack, err, rdata, busy, mem_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);
  always_comb begin
    any = |req;
    win = (req == 2'b11) ? ~last : req[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters, one access
// at a time through IDLE -> ISSUE -> CAPTURE, with registered read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int WDATA_W = DMEM_WDATA_W,
  parameter int RDATA_W = DMEM_RDATA_W,
  parameter int DEPTH   = DMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  state_t             state;
  logic               last;
  logic               win, any;
  logic               win_q, we_q, oor_q;
  logic [ADDR_W-1:0]  addr_sel;
  logic [WDATA_W-1:0] wdata_sel;
  logic               we_sel, oor_sel;
  logic [RDATA_W-1:0] rd_next;

  rr_arb2 u_arb (
    .req  (bus.req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    addr_sel  = win ? bus.addr1  : bus.addr0;
    wdata_sel = win ? bus.wdata1 : bus.wdata0;
    we_sel    = win ? bus.we[1]  : bus.we[0];
    oor_sel   = 32'(addr_sel) >= DEPTH_L;
    rd_next   = (we_q | oor_q) ? '0 : bus.mem_rdata;
  end

  // All bus outputs are registered; mem_en is set on the IDLE->ISSUE edge so
  // it is high exactly for the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      bus.ack       <= '0;
      bus.err       <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.ack    <= '0;
      bus.err    <= 1'b0;
      bus.mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            win_q         <= win;
            we_q          <= we_sel;
            oor_q         <= oor_sel;
            bus.mem_addr  <= addr_sel;
            bus.mem_wdata <= wdata_sel;
            bus.mem_en    <= we_sel & ~oor_sel;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          bus.rdata <= rd_next;
          bus.ack   <= win_q ? 2'b10 : 2'b01;
          bus.err   <= oor_q;
          last      <= win_q;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic init = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] mem [0:255];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 6) ? 16'hBEEF : 16'h0000;
    end else if (bus.mem_en) begin
      mem[bus.mem_addr] <= {8'h00, bus.mem_wdata};
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(negedge clk);
    init = 1'b0;
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b0;

    // write 0xA5 to 0x05 from requester 0
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 8'h05; bus.wdata0 = 8'hA5;
    @(negedge clk);
    chk("wr_issue_en", 32'(bus.mem_en), 1);
    chk("wr_issue_addr", 32'(bus.mem_addr), 'h05);
    chk("wr_issue_wdata", 32'(bus.mem_wdata), 'hA5);
    chk("wr_issue_busy", 32'(bus.busy), 1);
    chk("wr_issue_ack", 32'(bus.ack), 0);
    @(negedge clk);
    chk("wr_cap_en", 32'(bus.mem_en), 0);
    chk("wr_cap_ack", 32'(bus.ack), 0);
    @(negedge clk);
    chk("wr_ack", 32'(bus.ack), 'b01);
    chk("wr_err", 32'(bus.err), 0);
    chk("wr_rdata", 32'(bus.rdata), 0);
    chk("wr_busy", 32'(bus.busy), 0);
    bus.req = 2'b00;
    @(negedge clk);
    chk("wr_ack_pulse", 32'(bus.ack), 0);

    // read back 0x05
    bus.req = 2'b01; bus.we = 2'b00;
    @(negedge clk);
    chk("rd_issue_en", 32'(bus.mem_en), 0);
    @(negedge clk);
    chk("rd_cap_en", 32'(bus.mem_en), 0);
    @(negedge clk);
    chk("rd_ack", 32'(bus.ack), 'b01);
    chk("rd_rdata", 32'(bus.rdata), 'h00A5);
    chk("rd_err", 32'(bus.err), 0);
    bus.req = 2'b00;
    @(negedge clk);
    chk("rd_hold", 32'(bus.rdata), 'h00A5);
    chk("rd_ack_pulse", 32'(bus.ack), 0);

    // out-of-range write from requester 1
    bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 8'h40; bus.wdata1 = 8'h77;
    @(negedge clk);
    chk("oorw_issue_en", 32'(bus.mem_en), 0);
    @(negedge clk);
    chk("oorw_cap_en", 32'(bus.mem_en), 0);
    @(negedge clk);
    chk("oorw_ack", 32'(bus.ack), 'b10);
    chk("oorw_err", 32'(bus.err), 1);
    chk("oorw_rdata", 32'(bus.rdata), 0);
    bus.req = 2'b00;
    @(negedge clk);
    chk("oorw_err_pulse", 32'(bus.err), 0);
    chk("oorw_mem40", 32'(mem[8'h40]), 0);

    // both requesting continuously: 0,1,0,1 at 3-cycle spacing
    bus.we = 2'b00; bus.addr0 = 8'h05; bus.addr1 = 8'h06; bus.req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k % 3 == 2) begin
        chk($sformatf("rr_ack_k%0d", k), 32'(bus.ack), ((k / 3) % 2 == 0) ? 'b01 : 'b10);
        chk($sformatf("rr_rdata_k%0d", k), 32'(bus.rdata), ((k / 3) % 2 == 0) ? 'h00A5 : 'hBEEF);
      end else begin
        chk($sformatf("rr_ack_k%0d", k), 32'(bus.ack), 0);
      end
    end
    bus.req = 2'b00;
    @(negedge clk);
    chk("rr_idle_busy", 32'(bus.busy), 0);

    // out-of-range read from requester 1
    bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 8'h40;
    repeat (3) @(negedge clk);
    chk("oorr_ack", 32'(bus.ack), 'b10);
    chk("oorr_err", 32'(bus.err), 1);
    chk("oorr_rdata", 32'(bus.rdata), 0);
    bus.req = 2'b00;
    @(negedge clk);

    // request fields change during ISSUE; memory must see the latched ones
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 8'h10; bus.wdata0 = 8'h5A;
    @(negedge clk);
    chk("latch_issue_addr", 32'(bus.mem_addr), 'h10);
    chk("latch_issue_wdata", 32'(bus.mem_wdata), 'h5A);
    bus.addr0 = 8'h20; bus.wdata0 = 8'hFF;
    @(negedge clk);
    chk("latch_cap_addr", 32'(bus.mem_addr), 'h10);
    chk("latch_cap_wdata", 32'(bus.mem_wdata), 'h5A);
    @(negedge clk);
    chk("latch_ack", 32'(bus.ack), 'b01);
    bus.req = 2'b00;
    @(negedge clk);
    chk("latch_mem10", 32'(mem[8'h10]), 'h005A);
    chk("latch_mem20", 32'(mem[8'h20]), 0);

    // reset during ISSUE aborts the access; tie afterwards goes to 0
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 8'h07; bus.wdata0 = 8'h11;
    @(negedge clk);
    chk("abort_issue_en", 32'(bus.mem_en), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_mem_en", 32'(bus.mem_en), 0);
    chk("abort_mem_addr", 32'(bus.mem_addr), 0);
    chk("abort_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("abort_rdata", 32'(bus.rdata), 0);
    bus.req = 2'b00;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(bus.ack), 0);
    end
    rst = 1'b0;
    bus.we = 2'b00; bus.addr0 = 8'h05; bus.addr1 = 8'h06; bus.req = 2'b11;
    @(negedge clk);
    chk("post_rst_ack_c0", 32'(bus.ack), 0);
    @(negedge clk);
    chk("post_rst_ack_c1", 32'(bus.ack), 0);
    @(negedge clk);
    chk("post_rst_tie_ack", 32'(bus.ack), 'b01);
    chk("post_rst_tie_rdata", 32'(bus.rdata), 'h00A5);
    bus.req = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. It shares the memory between the CPU load/store port (requester 0) and the debug/loader port (requester 1). It runs every access through a fixed three-state sequence so the memory sees at most one operation at a time. It also returns registered 16-bit read data with a one-cycle acknowledge.

## Interface
- `ADDR_W`, default 8: address width.
- `WDATA_W`, default 8: write data width.
- `RDATA_W`, default 16: read data width.
- `DEPTH`, default 33: number of valid memory words; addresses ≥ DEPTH are out of range.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req[1:0]` in 2: per-requester access request, level.
- `we[1:0]` in 2: per-requester write (1) / read (0).
- `addr0`, `addr1` in ADDR_W: per-requester address.
- `wdata0`, `wdata1` in WDATA_W: per-requester write data.
- `ack[1:0]` out 2: one-cycle completion pulse to the granted requester.
- `err` out 1: valid with ack; the completed access was out of range.
- `rdata` out RDATA_W: read result, valid with ack.
- `busy` out 1: high in any state other than IDLE.
- `mem_en` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out WDATA_W: memory write data.
- `mem_rdata` in RDATA_W: memory read data, registered by the memory (1-cycle).

## Operation
- FSM states:
  - IDLE:
    - If any req is set, select the winner, latch its we/addr/wdata into internal regs, set the range flag (addr ≥ DEPTH), and go to ISSUE.
    - If no req is set, stay in IDLE.
  - ISSUE:
    - Drive mem_addr from the latched address.
    - mem_en = latched we AND in-range.
    - Go to CAPTURE.
  - CAPTURE:
    - mem_en = 0.
    - Latch mem_rdata into rdata for an in-range read; load 0 for a write or an out-of-range access.
    - Pulse ack[winner], set err = out-of-range.
    - Update the round-robin pointer to the winner.
    - Go to IDLE.
- Arbitration is round-robin:
  - When both req are set, the requester that was not served last wins.
  - The pointer resets to "last served = 1", so requester 0 wins the first tie.
  - A single requester always wins.
- Request fields are latched in IDLE. Later changes to req/addr/wdata during ISSUE/CAPTURE are ignored.
- The requester must deassert req in the ack cycle, or keep it high to issue another access. A req still high in IDLE after its ack is a new access.
- An out-of-range write never asserts mem_en. An out-of-range read returns rdata = 0 and err = 1.
- Width rules:
  - mem_wdata = latched wdata, zero-width conversions only.
  - rdata is the full RDATA_W memory word; no sign/zero extension is done here.
- mem_addr and mem_wdata hold their last latched values outside ISSUE. Only mem_en qualifies a write.

## Timing
- Reset values:
  - state = IDLE.
  - ack = 0, err = 0, rdata = 0, busy = 0, mem_en = 0, mem_addr = 0, mem_wdata = 0.
  - RR pointer = 1.
- Latency: req sampled in IDLE at edge N → mem_en/mem_addr valid in cycle N+1 → ack, rdata, err registered at edge N+2, visible in cycle N+2 for one cycle.
- Throughput: one access per 3 cycles. Back-to-back alternating requesters get 3-cycle spacing.
- The rdata register holds its value until the next CAPTURE. ack is high for exactly one cycle per access.
- Both req rising in the same cycle: one grant, and the loser is served in the next IDLE window with no extra idle cycle.
- rst asserted mid-access:
  - Immediate return to IDLE, all outputs to reset values.
  - No ack for the aborted access.
  - A write aborted in ISSUE may or may not have reached memory; callers re-issue after reset.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE, ISSUE, CAPTURE), default widths, `DMEM_DEPTH` constant.
- Optional sub-module `rr_arb2`: combinational 2-way round-robin winner from req[1:0] plus the last-served bit. Everything else is flat in `dmem_arbiter`.

## Test plan
- Reset, then req0 writes addr 0x05, data 0xA5 → mem_en high in exactly cycle N+1 with mem_addr 0x05 and mem_wdata 0xA5; ack[0] in cycle N+2, err = 0, rdata = 0.
- req0 reads addr 0x05 with the memory model returning 0x00A5 → ack[0] at N+2 with rdata 0x00A5, mem_en never high.
- Both req high continuously, reads → ack order 0,1,0,1, each ack 3 cycles apart, no missed grants.
- req1 writes addr 0x40 (≥ DEPTH 33) → mem_en stays 0, ack[1] at N+2 with err = 1; a following read of 0x40 → rdata 0, err 1.
- Change addr0/wdata0 during ISSUE → memory sees the values latched in IDLE.
- Assert rst during ISSUE → all outputs 0 within the same cycle, no ack; after release a tie goes to requester 0.
